etai_error_monitor: RTL
=======================

// Module: etai_error_monitor
// PURPOSE
//   Downstream stage of the ETAI approximate adder. Takes each operand pair and
//   the ETAI result {Cout,S} over a valid/ready stream. Computes the exact sum
//   and the absolute error distance (ED). Accumulates sample count, error count,
//   ED sum and maximum ED over a run of NUM samples started by `start`.
//   Used on-chip and in benches to characterise ETAI accuracy for a given N/K.
// PARAMETERS
//   N      16  operand width (must equal the ETAI instance's n)
//   CNT_W  32  width of the sample/error counters and of num_samples
//   ACC_W  48  width of the ED-sum accumulator
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        1-cycle pulse: clear stats, latch num_samples, begin run
//   num_samples  in   CNT_W    samples to accept in this run; sampled only on start
//   in_valid     in   1        x/y/s_approx/cout_approx valid
//   in_ready     out  1        monitor accepts a sample this cycle
//   x, y         in   N        operands that were fed to ETAI
//   s_approx     in   N        ETAI S
//   cout_approx  in   1        ETAI Cout
//   busy         out  1        state is RUN or DRAIN
//   done         out  1        state is DONE; stats stable
//   sample_cnt   out  CNT_W    samples accumulated
//   err_cnt      out  CNT_W    samples with ED != 0
//   ed_sum       out  ACC_W    sum of ED
//   ed_max       out  N+1      largest ED seen
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE. in_ready, busy and done are 0. All
//     stats and pipeline valids are 0.
//   - FSM states: IDLE, RUN, DRAIN, DONE.
//     IDLE/DONE --start--> RUN. Clears stats and the accepted-count; latches
//       num_samples. With num_samples=0, start goes directly to DONE and stats read 0.
//     RUN --accepted count reaches num_samples--> DRAIN.
//     DRAIN --both pipeline stages empty--> DONE.
//     DONE holds stats until the next start.
//     start is ignored in RUN and DRAIN.
//   - in_ready = (state==RUN) && (accepted < latched num_samples). It is a
//     registered-state function only, with no combinational path from in_valid.
//     A transfer occurs when in_valid && in_ready.
//   - Pipeline:
//     S1 registers x, y and approx = {cout_approx, s_approx} (N+1 bits).
//     S2 computes exact = x + y (N+1 bits, zero-extended operands) and
//       ED = |exact - approx| (N+1 bits, unsigned magnitude). It then updates the stats.
//     A sample is reflected in the stats on the 2nd rising edge after its handshake
//     edge. Throughput is 1 sample/cycle.
//   - Stats update on each S2-valid cycle:
//     sample_cnt += 1.
//     err_cnt += (ED != 0).
//     ed_sum += ED.
//     ed_max = max(ed_max, ED).
//   - Saturation: counters and ed_sum saturate at all-ones and never wrap.
//   - Boundaries:
//     Last-sample handshake and the RUN->DRAIN transition happen on the same edge.
//     in_valid while in_ready=0 is not consumed; upstream must hold it.
//     A start pulse on the cycle DONE is entered is taken on the next cycle if held.
//     rst_n low mid-run abandons the run and clears everything immediately.
// TESTING
//   Bench parameters: N=16, K=12. s_approx/cout_approx come from a live ETAI instance.
//   1. start, num_samples=1; x=0x0003, y=0x0004 -> ED=0.
//      done is 2-3 cycles after the handshake; sample_cnt=1, err_cnt=0, ed_sum=0, ed_max=0.
//   2. start, num_samples=3; pairs (0x000F,0x0001), (0x0008,0x0008), (0x00F8,0x0008),
//      sent back-to-back -> each ED=1; sample_cnt=3, err_cnt=3, ed_sum=3, ed_max=1.
//   3. start, num_samples=2; pairs (0xFFFF,0xFFFF) then (0x1234,0x0000).
//      Expected approx for the first pair: 0x1FFEF vs exact 0x1FFFE, ED=15.
//      Result: err_cnt=1, ed_sum=15, ed_max=15.
//   4. num_samples=4 with in_valid toggled randomly, plus a start pulse mid-run.
//      Required: exactly 4 handshakes; in_ready=0 after the 4th handshake; start
//      has no effect; stats match the reference model.
//   5. num_samples=0 -> done the cycle after start, all stats 0, in_ready never 1.
//   6. rst_n pulsed low mid-RUN after 2 of 5 samples -> all outputs 0 and state
//      IDLE immediately. A new start with num_samples=1 then runs cleanly.

Source files
------------

// File: rtl/etai_error_monitor.sv
// Accuracy monitor for the ETAI approximate adder: compares {cout,s} against the
// exact sum over a bounded run and accumulates count, error count, ED sum and max ED.
module etai_error_monitor #(
    parameter int unsigned N     = 16,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    input  logic [N-1:0]     s_approx,
    input  logic             cout_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N:0]       ed_max
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [N:0] abs_diff(input logic [N:0] a, input logic [N:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, num_q, num_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [N-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [N:0]       s1_approx_q, s1_approx_d, s2_ed_q, s2_ed_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
    logic [N:0]       ed_max_q, ed_max_d;
    logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
    logic             hs_s, clear_s;
    logic [N:0]       exact_s;
    logic [ACC_W:0]   sum_wide_s;

    // Run control: handshake accounting and state transitions
    always_comb begin
        hs_s      = in_valid && in_ready_q;
        state_d   = state_q;
        num_d     = num_q;
        clear_s   = 1'b0;
        acc_cnt_d = acc_cnt_q + {{(CNT_W-1){1'b0}}, hs_s};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear_s   = 1'b1;
                    num_d     = num_samples;
                    acc_cnt_d = {CNT_W{1'b0}};
                    state_d   = (num_samples == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (hs_s && (acc_cnt_d == num_q)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_RUN) && (acc_cnt_d < num_d);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    // Two-stage datapath: capture, then exact sum and error distance
    always_comb begin
        s1_valid_d = hs_s;
        if (hs_s) begin
            s1_x_d      = x;
            s1_y_d      = y;
            s1_approx_d = {cout_approx, s_approx};
        end else begin
            s1_x_d      = s1_x_q;
            s1_y_d      = s1_y_q;
            s1_approx_d = s1_approx_q;
        end
        exact_s    = {1'b0, s1_x_q} + {1'b0, s1_y_q};
        s2_valid_d = s1_valid_q;
        s2_ed_d    = abs_diff(exact_s, s1_approx_q);
    end

    // Statistics accumulation; all accumulators stick at all-ones
    always_comb begin
        sum_wide_s = {1'b0, ed_sum_q} + {{(ACC_W-N){1'b0}}, s2_ed_q};
        if (clear_s) begin
            sample_cnt_d = {CNT_W{1'b0}};
            err_cnt_d    = {CNT_W{1'b0}};
            ed_sum_d     = {ACC_W{1'b0}};
            ed_max_d     = {(N+1){1'b0}};
        end else if (s2_valid_q) begin
            sample_cnt_d = sat_inc(sample_cnt_q, 1'b1);
            err_cnt_d    = sat_inc(err_cnt_q, s2_ed_q != {(N+1){1'b0}});
            ed_sum_d     = sum_wide_s[ACC_W] ? {ACC_W{1'b1}} : sum_wide_s[ACC_W-1:0];
            ed_max_d     = (s2_ed_q > ed_max_q) ? s2_ed_q : ed_max_q;
        end else begin
            sample_cnt_d = sample_cnt_q;
            err_cnt_d    = err_cnt_q;
            ed_sum_d     = ed_sum_q;
            ed_max_d     = ed_max_q;
        end
    end

    // State, pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_cnt_q    <= {CNT_W{1'b0}};
            num_q        <= {CNT_W{1'b0}};
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_x_q       <= {N{1'b0}};
            s1_y_q       <= {N{1'b0}};
            s1_approx_q  <= {(N+1){1'b0}};
            s2_ed_q      <= {(N+1){1'b0}};
            sample_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q    <= {CNT_W{1'b0}};
            ed_sum_q     <= {ACC_W{1'b0}};
            ed_max_q     <= {(N+1){1'b0}};
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            num_q        <= num_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_approx_q  <= s1_approx_d;
            s2_ed_q      <= s2_ed_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ed_sum_q     <= ed_sum_d;
            ed_max_q     <= ed_max_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign ed_sum     = ed_sum_q;
    assign ed_max     = ed_max_q;

endmodule
